// File: rtl/ram_arbiter.sv
// Two-port arbiter (fetch i, data d) in front of a single-port synchronous RAM with 1-cycle read latency.
// Define RAM_ARB_RR_EN to use round-robin arbitration instead of fixed d priority with a starvation override.
module ram_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int               CNT_W      = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_r;
  logic             i_pend_r;
  logic             d_pend_r;
  logic             starve_hit_s;
  logic             i_gnt_s;
  logic             d_gnt_s;

`ifdef RAM_ARB_RR_EN
  logic             rr_d_r;  // 1: d wins the next tie, 0: i wins
`endif

  assign starve_hit_s = i_req && (starve_r == STARVE_LIM);

  // Grant selection; nothing is granted while reset is held
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (!rst_n) begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (i_req && d_req) begin
`ifdef RAM_ARB_RR_EN
      if (starve_hit_s || !rr_d_r) begin
        i_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
`else
      if (starve_hit_s) begin
        i_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
`endif
    end else begin
      i_gnt_s = i_req;
      d_gnt_s = d_req;
    end
  end

  // Consecutive-denial counter for the fetch port, saturating at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r <= {CNT_W{1'b0}};
    end else if (i_req && !i_gnt_s) begin
      if (starve_r != STARVE_LIM) begin
        starve_r <= starve_r + 4'd1;
      end else begin
        starve_r <= starve_r;
      end
    end else begin
      starve_r <= {CNT_W{1'b0}};
    end
  end

  // Read-owner flags: the RAM answers one cycle after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_pend_r <= 1'b0;
      d_pend_r <= 1'b0;
    end else begin
      i_pend_r <= i_gnt_s;
      d_pend_r <= d_gnt_s && !d_we;
    end
  end

`ifdef RAM_ARB_RR_EN
  // Round-robin pointer flips to the other port after every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_d_r <= 1'b1;
    end else if (d_gnt_s) begin
      rr_d_r <= 1'b0;
    end else if (i_gnt_s) begin
      rr_d_r <= 1'b1;
    end else begin
      rr_d_r <= rr_d_r;
    end
  end
`endif

  assign i_gnt       = i_gnt_s;
  assign d_gnt       = d_gnt_s;
  assign ram_wren    = d_gnt_s && d_we;
  assign ram_address = d_gnt_s ? d_addr : i_addr;
  assign ram_data    = d_wdata;
  assign i_rvalid    = i_pend_r;
  assign d_rvalid    = d_pend_r;
  assign i_rdata     = i_pend_r ? ram_q : {DATA_W{1'b0}};
  assign d_rdata     = d_pend_r ? ram_q : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised and directed bench for ram_arbiter against a transaction-level model with a shadow memory.
module tb_ram_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SM = 4;
  localparam int MW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, ram_wren;
  logic [DW-1:0] i_rdata, d_rdata, ram_data;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] ram_mem [0:63];

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  // model state
  int            m_wait;
  bit            m_rr_d, m_ipend, m_dpend;
  logic [DW-1:0] m_idata, m_ddata;
  logic [DW-1:0] ref_mem [0:63];
  bit            e_i, e_d;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data), .ram_q(ram_q)
  );

  // behavioural synchronous RAM
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address[MW-1:0]] <= ram_data;
    ram_q <= ram_mem[ram_address[MW-1:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_rr_d = 1'b1; m_ipend = 1'b0; m_dpend = 1'b0;
    m_idata = '0; m_ddata = '0;
  endtask

  // expected grants for the current inputs
  task automatic compute_expect();
    e_i = 1'b0; e_d = 1'b0;
    if (!rst_n) begin
      e_i = 1'b0; e_d = 1'b0;
    end else if (i_req && d_req) begin
`ifdef RAM_ARB_RR_EN
      if (m_wait == SM || !m_rr_d) e_i = 1'b1; else e_d = 1'b1;
`else
      if (m_wait == SM) e_i = 1'b1; else e_d = 1'b1;
`endif
    end else begin
      e_i = i_req; e_d = d_req;
    end
  endtask

  task automatic commit();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_wait  = (i_req && !e_i) ? ((m_wait < SM) ? m_wait + 1 : SM) : 0;
      m_ipend = e_i;
      m_idata = ref_mem[i_addr[MW-1:0]];
      m_dpend = e_d && !d_we;
      m_ddata = ref_mem[d_addr[MW-1:0]];
      if (e_d && d_we) ref_mem[d_addr[MW-1:0]] = d_wdata;
      if (e_d) m_rr_d = 1'b0;
      else if (e_i) m_rr_d = 1'b1;
    end
  endtask

  task automatic apply();
    compute_expect();
    #2;
  endtask

  task automatic advance();
    @(posedge clk);
    commit();
    #1;
  endtask

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("i_gnt", 64'(i_gnt), 64'(e_i));
      check("d_gnt", 64'(d_gnt), 64'(e_d));
      check("ram_wren", 64'(ram_wren), 64'(e_d && d_we));
      check("ram_address", 64'(ram_address), 64'(e_d ? d_addr : i_addr));
      check("ram_data", 64'(ram_data), 64'(d_wdata));
      check("i_rvalid", 64'(i_rvalid), 64'(rst_n && m_ipend));
      check("i_rdata", 64'(i_rdata), 64'((rst_n && m_ipend) ? m_idata : 32'h0));
      check("d_rvalid", 64'(d_rvalid), 64'(rst_n && m_dpend));
      check("d_rdata", 64'(d_rdata), 64'((rst_n && m_dpend) ? m_ddata : 32'h0));
    end
  end

  initial begin
    logic [DW-1:0] v;
    for (int k = 0; k < 64; k++) begin
      v = $urandom;
      ram_mem[k] = v;
      ref_mem[k] = v;
    end
    ram_mem[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    model_reset();

    // reset with both requests asserted
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 30'h1; d_addr = 30'h2;
    repeat (2) @(posedge clk);
    #1;
    apply();
    chk_en = 1'b1;
    check("rst_i_gnt", 64'(i_gnt), 64'd0);
    check("rst_d_gnt", 64'(d_gnt), 64'd0);
    check("rst_wren", 64'(ram_wren), 64'd0);
    check("rst_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
    check("rst_rdata", 64'(i_rdata | d_rdata), 64'd0);
    advance();
    rst_n = 1'b1;
    apply();
    check("first_d_gnt", 64'(d_gnt), 64'd1);
    advance();

    // single fetch
    d_req = 1'b0; i_req = 1'b1; i_addr = 30'h10;
    apply();
    check("fetch_gnt", 64'(i_gnt), 64'd1);
    advance();
    i_req = 1'b0;
    apply();
    check("fetch_rvalid", 64'(i_rvalid), 64'd1);
    check("fetch_rdata", 64'(i_rdata), 64'hDEADBEEF);
    check("fetch_d_rvalid", 64'(d_rvalid), 64'd0);
    advance();

    // write then read the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h2F; d_wdata = 32'h12345678;
    apply();
    check("wr_wren", 64'(ram_wren), 64'd1);
    advance();
    d_we = 1'b0; d_wdata = 32'h0;
    apply();
    check("rd_wren", 64'(ram_wren), 64'd0);
    check("wr_no_rvalid", 64'(d_rvalid), 64'd0);
    advance();
    d_req = 1'b0;
    apply();
    check("raw_rvalid", 64'(d_rvalid), 64'd1);
    check("raw_rdata", 64'(d_rdata), 64'h12345678);
    advance();

    // contention from a fresh reset
    rst_n = 1'b0;
    apply();
    advance();
    rst_n = 1'b1;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 30'h10; d_addr = 30'h0;
    for (int c = 0; c < 15; c++) begin
      apply();
`ifdef RAM_ARB_RR_EN
      check("rr_pattern", 64'(d_gnt), 64'((c % 2) == 0));
`else
      check("starve_pattern", 64'(d_gnt), 64'((c % 5) != 4));
`endif
      advance();
      if (e_d) d_addr = 30'(c + 1);
    end

    // reset while a read is outstanding
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 30'h2F;
    apply();
    check("mid_gnt", 64'(d_gnt), 64'd1);
    advance();
    rst_n = 1'b0;
    apply();
    check("mid_rvalid_drop", 64'(d_rvalid), 64'd0);
    check("mid_rdata_zero", 64'(d_rdata), 64'd0);
    advance();
    rst_n = 1'b1; d_req = 1'b0;
    apply();
    advance();

    // randomised traffic with held requests and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if (!i_req || e_i) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = 30'($urandom_range(0, 63));
      end
      if (!d_req || e_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = 30'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
      rst_n = ($urandom_range(0, 299) != 0);
      apply();
      advance();
    end
    rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0;
    apply();
    advance();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
